md_issue_unit: RTL

- E-stage front end of the multiply/divide unit. It sits directly upstream of it and drives its start, MDCCtrl, SrcA/SrcB, MDM_WD, MDM_WE and MDM_RE inputs.
- Accepts decoded md-class ops (calc / mthi,mtlo / mfhi,mflo) and sequences them against the unit's busy.
- Generates the E-stage stall.
- Suppresses issue on interrupt request.
- Runs a latency watchdog.

---
 rtl/md_pkg.sv | 51 +++++
 rtl/md_wdog.sv | 59 +++++
 rtl/md_issue_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue front end: op classes,
// hi/lo selects, ctrl codes, FSM states and small decode helpers.
package md_pkg;

  typedef enum logic [1:0] {
    MD_CLS_NONE = 2'b00,
    MD_CLS_CALC = 2'b01,
    MD_CLS_MT   = 2'b10,
    MD_CLS_MF   = 2'b11
  } md_cls_e;

  localparam logic [1:0] MD_SEL_NONE = 2'b00;
  localparam logic [1:0] MD_SEL_HI   = 2'b01;
  localparam logic [1:0] MD_SEL_LO   = 2'b10;

  localparam logic [2:0] MD_CTRL_MULT  = 3'b000;
  localparam logic [2:0] MD_CTRL_MULTU = 3'b001;
  localparam logic [2:0] MD_CTRL_DIV   = 3'b010;
  localparam logic [2:0] MD_CTRL_DIVU  = 3'b011;
  localparam logic [2:0] MD_CTRL_MADD  = 3'b100;

  localparam int MD_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RUN   = 2'b10,
    ST_WRITE = 2'b11
  } md_state_e;

  function automatic logic md_is_short(input logic [2:0] ctrl);
    logic short_s;
    case (ctrl)
      MD_CTRL_MULT, MD_CTRL_MULTU, MD_CTRL_MADD: short_s = 1'b1;
      default:                                   short_s = 1'b0;
    endcase
    return short_s;
  endfunction

  // Only the exact 001/010 codes name hi/lo; anything else is a no-op.
  function automatic logic [1:0] md_hilo_sel(input logic [2:0] sel);
    logic [1:0] hl_s;
    case (sel)
      3'b001:  hl_s = MD_SEL_HI;
      3'b010:  hl_s = MD_SEL_LO;
      default: hl_s = MD_SEL_NONE;
    endcase
    return hl_s;
  endfunction

endpackage

// File: rtl/md_wdog.sv
// Latency watchdog: counts busy cycles of an in-flight op and raises a
// sticky error once the ctrl-dependent limit is reached.
module md_wdog
  import md_pkg::*;
#(
  parameter int MUL_LAT   = 5,
  parameter int DIV_LAT   = 10,
  parameter int TMO_SLACK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [2:0] ctrl_i,
  output logic       hit_o,
  output logic       err_o
);

  localparam logic [MD_CNT_W-1:0] LIM_SHORT = MD_CNT_W'(MUL_LAT + TMO_SLACK);
  localparam logic [MD_CNT_W-1:0] LIM_LONG  = MD_CNT_W'(DIV_LAT + TMO_SLACK);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s, limit_s;
  logic                err_q, err_d;

  assign limit_s   = md_is_short(ctrl_i) ? LIM_SHORT : LIM_LONG;
  assign cnt_inc_s = cnt_q + MD_CNT_W'(1);
  assign hit_o     = inc_i & (cnt_inc_s >= limit_s);
  assign err_o     = err_q;

  // Next count and sticky error flag.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_inc_s;
      if (hit_o) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/md_issue_unit.sv
// E-stage issue front end for the multiply/divide unit: sequencing, stall,
// interrupt suppression and watchdog. Perf counters under MD_ISSUE_PERF_EN.
module md_issue_unit
  import md_pkg::*;
#(
  parameter int MUL_LAT   = 5,
  parameter int DIV_LAT   = 10,
  parameter int TMO_SLACK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_cls,
  input  logic [2:0]  op_sel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        int_req,
  input  logic        md_busy,
  input  logic [31:0] md_rd,
  output logic        md_start,
  output logic [2:0]  md_ctrl,
  output logic [31:0] md_srca,
  output logic [31:0] md_srcb,
  output logic [31:0] md_wd,
  output logic [1:0]  md_we,
  output logic [1:0]  md_re,
  output logic [31:0] mf_data,
  output logic        stall_e,
  output logic        wdog_err
`ifdef MD_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_calc_cnt
`endif
);

  md_state_e   state_q, state_d;
  logic        md_start_q, md_start_d;
  logic [2:0]  md_ctrl_q, md_ctrl_d;
  logic [31:0] md_srca_q, md_srca_d;
  logic [31:0] md_srcb_q, md_srcb_d;
  logic [31:0] md_wd_q, md_wd_d;
  logic [1:0]  md_we_q, md_we_d;

  md_cls_e cls_s;
  logic    cls_valid_s, accept_s;
  logic    wdog_clr_s, wdog_inc_s, wdog_hit_s;

  assign cls_s       = md_cls_e'(op_cls);
  assign cls_valid_s = op_valid & (cls_s != MD_CLS_NONE);
  assign accept_s    = cls_valid_s & (state_q == ST_IDLE) & ~md_busy & ~int_req;
  // An interrupt flushes E, so it never stalls.
  assign stall_e     = cls_valid_s & ~accept_s & ~int_req;
  assign md_re       = (accept_s && cls_s == MD_CLS_MF) ? md_hilo_sel(op_sel) : MD_SEL_NONE;
  assign mf_data     = (md_re != MD_SEL_NONE) ? md_rd : 32'd0;

  assign wdog_clr_s  = (state_q == ST_ISSUE) & ~int_req;
  assign wdog_inc_s  = (state_q == ST_RUN) & md_busy;

  assign md_start = md_start_q;
  assign md_ctrl  = md_ctrl_q;
  assign md_srca  = md_srca_q;
  assign md_srcb  = md_srcb_q;
  assign md_wd    = md_wd_q;
  assign md_we    = md_we_q;

  md_wdog #(
    .MUL_LAT   (MUL_LAT),
    .DIV_LAT   (DIV_LAT),
    .TMO_SLACK (TMO_SLACK)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (wdog_clr_s),
    .inc_i  (wdog_inc_s),
    .ctrl_i (md_ctrl_q),
    .hit_o  (wdog_hit_s),
    .err_o  (wdog_err)
  );

  // FSM next state and next registered outputs; start/we are one-cycle pulses.
  always_comb begin
    state_d    = state_q;
    md_start_d = 1'b0;
    md_ctrl_d  = md_ctrl_q;
    md_srca_d  = md_srca_q;
    md_srcb_d  = md_srcb_q;
    md_wd_d    = md_wd_q;
    md_we_d    = MD_SEL_NONE;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (cls_s)
            MD_CLS_CALC: begin
              md_start_d = 1'b1;
              md_ctrl_d  = op_sel;
              md_srca_d  = rs_val;
              md_srcb_d  = rt_val;
              state_d    = ST_ISSUE;
            end
            MD_CLS_MT: begin
              md_wd_d = rs_val;
              md_we_d = md_hilo_sel(op_sel);
              state_d = ST_WRITE;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (int_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!md_busy || wdog_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      md_start_q <= 1'b0;
      md_ctrl_q  <= 3'b000;
      md_srca_q  <= 32'd0;
      md_srcb_q  <= 32'd0;
      md_wd_q    <= 32'd0;
      md_we_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      md_start_q <= md_start_d;
      md_ctrl_q  <= md_ctrl_d;
      md_srca_q  <= md_srca_d;
      md_srcb_q  <= md_srcb_d;
      md_wd_q    <= md_wd_d;
      md_we_q    <= md_we_d;
    end
  end

`ifdef MD_ISSUE_PERF_EN
  logic [31:0] perf_stall_q, perf_calc_q;

  assign perf_stall_cnt = perf_stall_q;
  assign perf_calc_cnt  = perf_calc_q;

  // Free-running performance counters, wrapping naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= 32'd0;
      perf_calc_q  <= 32'd0;
    end else begin
      if (stall_e) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end else begin
        perf_stall_q <= perf_stall_q;
      end
      if (accept_s && cls_s == MD_CLS_CALC) begin
        perf_calc_q <= perf_calc_q + 32'd1;
      end else begin
        perf_calc_q <= perf_calc_q;
      end
    end
  end
`endif

endmodule
